mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width in bits.
REQ-002 SHALL have parameter DW, default 32, meaning data width in bits; byte enable width is DW/8.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive denied fetch cycles before fetch is promoted.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port m0_req/m0_addr, input, 1/AW, the instruction-fetch read request (read-only master).
REQ-007 SHALL have port m0_gnt/m0_rvalid, output, 1/1, the fetch grant and read-data-valid.
REQ-008 SHALL have port m1_req/m1_we/m1_be/m1_addr/m1_wdata, input, 1/1/DW/8/AW/DW, the load-store request.
REQ-009 SHALL have port m1_gnt/m1_rvalid, output, 1/1, the load-store grant and read-data-valid.
REQ-010 SHALL have port m2_req/m2_lock/m2_we/m2_be/m2_addr/m2_wdata, input, 1/1/1/DW/8/AW/DW, the debug/loader request plus bus-lock.
REQ-011 SHALL have port m2_gnt/m2_rvalid, output, 1/1, the debug grant and read-data-valid.
REQ-012 SHALL have port rdata, output, DW, shared read data broadcast to all masters, qualified by mX_rvalid.
REQ-013 SHALL have port s_en/s_we/s_be/s_addr/s_wdata, output, 1/1/DW/8/AW/DW, the single-port memory command.
REQ-014 SHALL have port s_rdata, input, DW, memory read data, valid the cycle after an s_en read.

Function
REQ-015 SHALL grant at most one master per cycle, combinationally in the same cycle as its req; a granted request is accepted by the memory that cycle.
REQ-016 SHALL use default priority m2 > m1 > m0.
REQ-017 SHALL keep starve_cnt: +1 each cycle m0_req=1 and m0_gnt=0, saturating at STARVE_LIMIT; cleared when m0_gnt=1 or m0_req=0.
REQ-018 SHALL, when starve_cnt==STARVE_LIMIT and m0_req=1 in state IDLE, rank m0 above m1 (m2 still highest).
REQ-019 SHALL implement FSM {IDLE, DBG_OWN}: IDLE->DBG_OWN when m2_gnt=1 and m2_lock=1; DBG_OWN->IDLE on the first cycle m2_lock=0 (that cycle arbitrates as IDLE).
REQ-020 SHALL, in DBG_OWN, grant only m2; m0_gnt=m1_gnt=0 regardless of starve_cnt (starve_cnt still counts).
REQ-021 SHALL drive s_en = OR of grants; s_addr/s_wdata/s_be/s_we from the winner; s_we=0 when m0 wins; s_* other than s_en are don't-care when s_en=0.
REQ-022 SHALL register {rsp_valid, rsp_id} on every granted read (we=0); next cycle exactly the owner's mX_rvalid=1 for one cycle with rdata=s_rdata.
REQ-023 SHALL generate no rvalid for writes.
REQ-024 SHALL support back-to-back reads from different masters every cycle with no bubble; responses return in grant order, latency exactly 1.
REQ-025 SHALL allow a master to drop req without grant; no state is retained for ungranted requests.
REQ-026 SHALL assert no grant to a master whose req=0.

Reset
REQ-027 SHALL, while rst=1, force all mX_gnt=0, s_en=0, all mX_rvalid=0, state=IDLE, starve_cnt=0, rsp_valid=0.
REQ-028 SHALL discard a read granted in the cycle rst rises; no rvalid in the cycle after reset deasserts.

Verification
REQ-029 SHALL verify simultaneous m0/m1/m2 reads at 0x10/0x20/0x30 -> m2_gnt only; m2_rvalid next cycle with rdata=mem[0x30].
REQ-030 SHALL verify m1_req and m0_req held for 6 cycles -> m1 granted cycles 1-4, m0 granted cycle 5, m1 cycle 6; starve_cnt returns to 0.
REQ-031 SHALL verify m2_lock=1 for 3 writes to 0x0-0x8 with m0_req=1 and m1_req=1 -> only m2_gnt; m0 granted the cycle after m2_lock=0 (starve saturated).
REQ-032 SHALL verify alternating m0/m1 reads each cycle -> m0_rvalid/m1_rvalid alternate one cycle later, no bubble, correct data.
REQ-033 SHALL verify m1 write 0xDEADBEEF with be=4'b0011 to 0x40, then m0 read 0x40 -> no rvalid for write; m0 rdata low half 0xBEEF.
REQ-034 SHALL verify rst asserted in the cycle after a granted m1 read -> m1_rvalid=0, all gnt=0 during reset, IDLE after.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: three-master request/grant bus plus single-port memory command/response
interface mem_bus_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic          m0_gnt, m0_rvalid;
  logic          m1_req, m1_we;
  logic [DW/8-1:0] m1_be;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt, m1_rvalid;
  logic          m2_req, m2_lock, m2_we;
  logic [DW/8-1:0] m2_be;
  logic [AW-1:0] m2_addr;
  logic [DW-1:0] m2_wdata;
  logic          m2_gnt, m2_rvalid;
  logic [DW-1:0] rdata;
  logic          s_en, s_we;
  logic [DW/8-1:0] s_be;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  modport master (
    output m0_req, m0_addr, m1_req, m1_we, m1_be, m1_addr, m1_wdata,
           m2_req, m2_lock, m2_we, m2_be, m2_addr, m2_wdata, s_rdata,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m2_gnt, m2_rvalid, rdata,
           s_en, s_we, s_be, s_addr, s_wdata
  );
  modport slave (
    input  m0_req, m0_addr, m1_req, m1_we, m1_be, m1_addr, m1_wdata,
           m2_req, m2_lock, m2_we, m2_be, m2_addr, m2_wdata, s_rdata,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m2_gnt, m2_rvalid, rdata,
           s_en, s_we, s_be, s_addr, s_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: fixed-priority fetch/load-store/debug arbiter with fetch anti-starvation and debug bus lock
module mem_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  mem_bus_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic {IDLE, DBG_OWN} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_starve;
  logic r_rsp_valid;
  logic [1:0] r_rsp_id;
  logic w_own, w_starved, w_g0, w_g1, w_g2, w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [DW/8-1:0] w_be;
  always_comb begin
    w_own = r_state == DBG_OWN && bus.m2_lock;
    w_starved = r_starve == CW'(STARVE_LIMIT);
    w_g2 = !rst && bus.m2_req;
    w_g0 = !rst && !w_own && !bus.m2_req && bus.m0_req && (w_starved || !bus.m1_req);
    w_g1 = !rst && !w_own && !bus.m2_req && bus.m1_req && !w_g0;
    w_next = bus.m2_lock && (r_state == DBG_OWN || w_g2) ? DBG_OWN : IDLE;
    w_addr = w_g2 ? bus.m2_addr : w_g1 ? bus.m1_addr : bus.m0_addr;
    w_wdata = w_g2 ? bus.m2_wdata : bus.m1_wdata;
    w_be = w_g2 ? bus.m2_be : w_g1 ? bus.m1_be : '1;
    w_we = w_g2 ? bus.m2_we : w_g1 && bus.m1_we;
  end
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id <= 2'd0;
    end else begin
      r_starve <= (!bus.m0_req || w_g0) ? '0 : w_starved ? r_starve : r_starve + CW'(1);
      r_rsp_valid <= (w_g0 || w_g1 || w_g2) && !w_we;
      r_rsp_id <= w_g2 ? 2'd2 : w_g1 ? 2'd1 : 2'd0;
    end
  end
  assign bus.m0_gnt = w_g0;
  assign bus.m1_gnt = w_g1;
  assign bus.m2_gnt = w_g2;
  assign bus.s_en = w_g0 || w_g1 || w_g2;
  assign bus.s_we = w_we;
  assign bus.s_be = w_be;
  assign bus.s_addr = w_addr;
  assign bus.s_wdata = w_wdata;
  assign bus.rdata = bus.s_rdata;
  // a response registered just before reset is suppressed while rst is high
  assign bus.m0_rvalid = !rst && r_rsp_valid && r_rsp_id == 2'd0;
  assign bus.m1_rvalid = !rst && r_rsp_valid && r_rsp_id == 2'd1;
  assign bus.m2_rvalid = !rst && r_rsp_valid && r_rsp_id == 2'd2;
endmodule
